// File: rtl/adder_pipe.sv
// -----------------------------------------------------------------------------
// adder_pipe
//   Two-stage pipelined multi-lane unsigned adder with valid/ready handshakes
//   on both sides. The mode input selects wrap, saturate, accumulate or clear
//   for every lane at once. Each lane keeps its own accumulator.
//
//   Stage S1 registers the raw (WIDTH+1)-bit sum of each lane plus the mode.
//   Stage S2 applies the mode, updates the accumulators and drives the
//   outputs.
//
// Parameters
//   WIDTH        bits per operand / result lane
//   LANES        number of independent lanes (>= 1)
//
// Ports
//   clock_reset  [0] clock (rising edge), [1] reset_n (async, active-low)
//   i            lane k operands at i[2*WIDTH*k +: 2*WIDTH]; a = low half, b = high half
//   mode         00 wrap, 01 saturate, 10 accumulate, 11 clear accumulator
//   in_valid     i/mode carry a transaction this cycle
//   in_ready     block can accept (combinationally depends on out_ready)
//   o            lane k result at o[WIDTH*k +: WIDTH]
//   flag         per-lane overflow (carry-out or saturation)
//   out_valid    o/flag hold a transaction
//   out_ready    consumer accepts the transaction on o/flag
// -----------------------------------------------------------------------------
module adder_pipe #(
    parameter int WIDTH = 4,
    parameter int LANES = 1
) (
    input  logic [1:0]             clock_reset,
    input  logic [2*WIDTH*LANES-1:0] i,
    input  logic [1:0]             mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH*LANES-1:0] o,
    output logic [LANES-1:0]       flag,
    output logic                   out_valid,
    input  logic                   out_ready
);

    typedef enum logic [1:0] {
        MODE_WRAP = 2'b00,
        MODE_SAT  = 2'b01,
        MODE_ACC  = 2'b10,
        MODE_CLR  = 2'b11
    } mode_e;

    logic clk;
    logic rst_n;

    assign clk   = clock_reset[0];
    assign rst_n = clock_reset[1];

    // Packed views: lane k occupies the k-th slice, lane 0 at the LSBs, so
    // these map bit-for-bit onto the flat i / o ports.
    logic [LANES-1:0][1:0][WIDTH-1:0] in_lanes;
    assign in_lanes = i;

    // -------------------------------------------------------------------------
    // Pipeline state
    // -------------------------------------------------------------------------
    logic                         s1_valid_q;
    mode_e                        s1_mode_q;
    logic [LANES-1:0][WIDTH:0]    s1_sum_q;
    logic [LANES-1:0][WIDTH:0]    s1_sum_d;

    logic                         s2_valid_q;
    logic [LANES-1:0][WIDTH-1:0]  s2_res_q;
    logic [LANES-1:0][WIDTH-1:0]  s2_res_d;
    logic [LANES-1:0]             s2_flag_q;
    logic [LANES-1:0]             s2_flag_d;

    logic [LANES-1:0][WIDTH-1:0]  acc_q;
    logic [LANES-1:0][WIDTH-1:0]  acc_d;

    logic                         s1_take;
    logic                         s2_take;

    // -------------------------------------------------------------------------
    // Handshake: a stage loads when it is empty or its content is leaving.
    // -------------------------------------------------------------------------
    assign s2_take = !s2_valid_q || out_ready;
    assign s1_take = !s1_valid_q || s2_take;

    // Gated by rst_n so the producer sees not-ready for the whole reset.
    assign in_ready = rst_n && s1_take;

    // -------------------------------------------------------------------------
    // S1 datapath: raw sum with carry
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        s1_sum_d = '0;
        for (int k = 0; k < LANES; k++) begin
            s1_sum_d[k] = (WIDTH+1)'(in_lanes[k][0]) + (WIDTH+1)'(in_lanes[k][1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // flops sample pre-edge values regardless of process ordering.
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_WRAP;
            s1_sum_q   <= '0;
        end else if (s1_take) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_mode_q <= mode_e'(mode);
                s1_sum_q  <= s1_sum_d;
            end
        end
    end

    // -------------------------------------------------------------------------
    // S2 datapath: apply mode, compute next accumulator value
    // -------------------------------------------------------------------------
    logic [WIDTH+1:0] acc_sum;

    always_comb begin
        s2_res_d  = '0;
        s2_flag_d = '0;
        acc_d     = acc_q;
        acc_sum   = '0;
        for (int k = 0; k < LANES; k++) begin
            // Two guard bits: acc (WIDTH) + sum (WIDTH+1) can need WIDTH+2 bits.
            acc_sum = (WIDTH+2)'(acc_q[k]) + (WIDTH+2)'(s1_sum_q[k]);
            unique case (s1_mode_q)
                MODE_WRAP: begin
                    s2_res_d[k]  = s1_sum_q[k][WIDTH-1:0];
                    s2_flag_d[k] = s1_sum_q[k][WIDTH];
                end
                MODE_SAT: begin
                    s2_res_d[k]  = s1_sum_q[k][WIDTH] ? {WIDTH{1'b1}}
                                                      : s1_sum_q[k][WIDTH-1:0];
                    s2_flag_d[k] = s1_sum_q[k][WIDTH];
                end
                MODE_ACC: begin
                    acc_d[k]     = acc_sum[WIDTH-1:0];
                    s2_res_d[k]  = acc_sum[WIDTH-1:0];
                    s2_flag_d[k] = |acc_sum[WIDTH+1:WIDTH];
                end
                MODE_CLR: begin
                    acc_d[k]     = '0;
                    s2_res_d[k]  = '0;
                    s2_flag_d[k] = 1'b0;
                end
                default: begin
                    s2_res_d[k]  = '0;
                    s2_flag_d[k] = 1'b0;
                end
            endcase
        end
    end

    // Accumulators commit only when an item actually moves S1 -> S2, so an
    // item held in S1 during a stall is never applied twice.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the accumulators are state visible to software-level behaviour
        // and must start at zero, so they are reset like the pipeline flops.
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_flag_q  <= '0;
            acc_q      <= '0;
        end else if (s2_take) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_res_q  <= s2_res_d;
                s2_flag_q <= s2_flag_d;
                acc_q     <= acc_d;
            end
        end
    end

    assign o         = s2_res_q;
    assign flag      = s2_flag_q;
    assign out_valid = s2_valid_q;

endmodule

// File: tb/tb_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe
//   Directed bench for adder_pipe at WIDTH=4, LANES=2. Expected results come
//   from a behavioural model evaluated when a transaction is accepted and are
//   queued; a monitor pops and compares on every output transfer.
//   Inputs change 2 time units after a rising edge; outputs are sampled on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_adder_pipe;

    localparam int WIDTH = 4;
    localparam int LANES = 2;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  o;
    logic [1:0]  flag;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] o;
        logic [1:0] f;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] acc_m[2];

    adder_pipe #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clock_reset ({rst_n, clk}),
        .i           (din),
        .mode        (mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .o           (o),
        .flag        (flag),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference of one transaction; updates the model accumulators.
    function automatic exp_t model(input logic [15:0] d, input logic [1:0] m);
        exp_t       e;
        logic [3:0] a, b;
        logic [4:0] s;
        logic [5:0] t;
        e = '0;
        for (int k = 0; k < 2; k++) begin
            a = d[8*k +: 4];
            b = d[8*k+4 +: 4];
            s = {1'b0, a} + {1'b0, b};
            case (m)
                2'b00: begin e.o[4*k +: 4] = s[3:0]; e.f[k] = s[4]; end
                2'b01: begin e.o[4*k +: 4] = s[4] ? 4'hF : s[3:0]; e.f[k] = s[4]; end
                2'b10: begin
                    t = {2'b00, acc_m[k]} + {1'b0, s};
                    acc_m[k] = t[3:0];
                    e.o[4*k +: 4] = t[3:0];
                    e.f[k] = |t[5:4];
                end
                default: begin acc_m[k] = 4'h0; e.o[4*k +: 4] = 4'h0; e.f[k] = 1'b0; end
            endcase
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present one transaction and hold it until accepted (bounded).
    task automatic send(input logic [15:0] d, input logic [1:0] m);
        bit done = 0;
        din      = d;
        mode     = m;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(d, m));
                done = 1;
            end
            step();
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 30 && sb.size() != 0; n++) step();
        check("drain_empty", sb.size(), 32'd0);
    endtask

    // Output monitor: every output transfer must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_o", o, e.o);
                check("sb_flag", flag, e.f);
            end
        end
    end

    initial begin
        logic [7:0] held_o;
        logic [1:0] held_f;

        rst_n     = 1'b0;
        din       = '0;
        mode      = 2'b00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        acc_m     = '{4'h0, 4'h0};

        // 1. Reset for 3 cycles, then release
        repeat (3) step();
        check("rst_in_ready_low", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_out_valid", out_valid, 1'b0);
        check("post_rst_o", o, 8'h00);
        check("post_rst_flag", flag, 2'b00);
        step();

        // 2. Wrap: lane0 (3,4), lane1 (9,8) with latency check
        send({4'd8, 4'd9, 4'd4, 4'd3}, 2'b00);
        in_valid = 1'b0;
        @(negedge clk);
        check("wrap_lat_not_yet", out_valid, 1'b0);
        step();
        @(negedge clk);
        check("wrap_lat_valid", out_valid, 1'b1);
        check("wrap_o", o, 8'h17);
        check("wrap_flag", flag, 2'b10);
        step();

        // 3. Saturate
        send({4'd15, 4'd15, 4'd8, 4'd9}, 2'b01);
        send({4'd15, 4'd15, 4'd2, 4'd2}, 2'b01);
        in_valid = 1'b0;
        drain();

        // 4. Accumulate back-to-back, clear, then read accumulator
        send({4'd0, 4'd0, 4'd4, 4'd3}, 2'b10);
        send({4'd0, 4'd0, 4'd1, 4'd1}, 2'b10);
        send({4'd0, 4'd0, 4'd0, 4'd15}, 2'b10);
        send({4'd0, 4'd0, 4'd0, 4'd0}, 2'b11);
        send({4'd0, 4'd0, 4'd0, 4'd0}, 2'b10);
        in_valid = 1'b0;
        drain();
        check("acc_cleared", acc_m[0], 4'h0);

        // 5. Backpressure: two items fill the pipe, third is refused
        out_ready = 1'b0;
        send({4'd5, 4'd5, 4'd2, 4'd1}, 2'b10);
        send({4'd1, 4'd7, 4'd0, 4'd3}, 2'b10);
        din      = {4'd3, 4'd3, 4'd4, 4'd4};
        mode     = 2'b10;
        in_valid = 1'b1;
        @(negedge clk);
        check("stall_in_ready_low", in_ready, 1'b0);
        check("stall_out_valid", out_valid, 1'b1);
        held_o = o;
        held_f = flag;
        for (int n = 0; n < 3; n++) begin
            step();
            @(negedge clk);
            check("stall_hold_o", o, held_o);
            check("stall_hold_flag", flag, held_f);
            check("stall_hold_in_ready", in_ready, 1'b0);
        end
        step();
        out_ready = 1'b1;
        send({4'd3, 4'd3, 4'd4, 4'd4}, 2'b10);
        send({4'd9, 4'd0, 4'd1, 4'd2}, 2'b10);
        in_valid = 1'b0;
        drain();

        // 6. Async reset with two accumulate items in flight
        out_ready = 1'b0;
        send({4'd1, 4'd1, 4'd1, 4'd1}, 2'b10);
        send({4'd2, 4'd2, 4'd2, 4'd2}, 2'b10);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_o", o, 8'h00);
        check("async_rst_in_ready", in_ready, 1'b0);
        sb.delete();
        acc_m = '{4'h0, 4'h0};
        step();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        send({4'd1, 4'd1, 4'd1, 4'd1}, 2'b10);
        in_valid = 1'b0;
        begin
            bit seen = 0;
            for (int n = 0; n < 10 && !seen; n++) begin
                @(negedge clk);
                if (out_valid) begin
                    seen = 1;
                    check("post_async_acc_o", o, 8'h22);
                    check("post_async_acc_flag", flag, 2'b00);
                end
                step();
            end
            if (!seen) check("post_async_timeout", 32'd0, 32'd1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
